// File: rtl/mem_sram_controller.sv
// rtl/mem_sram_controller.sv - memory-stage responder splitting 32-bit accesses into two 16-bit async SRAM transfers
module mem_sram_controller #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] MEM_BASE    = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en_in,
   input  logic        mem_w_en_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] val_rm_in,
   output logic        ready,
   output logic [31:0] read_data_out,
   output logic [17:0] sram_addr,
   inout  wire  [15:0] sram_dq,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n,
   output logic        sram_ce_n,
   output logic        sram_oe_n
);

   // Counter must hold 0..WAIT_CYCLES-1; keep at least one bit for WAIT_CYCLES=1.
   localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [15:0]   stage_lo;

   logic          request;
   logic          is_write;
   logic          in_phase;
   logic          last;
   logic [16:0]   word;
   logic          dq_drive;
   logic [15:0]   dq_out;

   assign request  = mem_r_en_in | mem_w_en_in;
   // A simultaneous read and write strobe is served as a write.
   assign is_write = mem_w_en_in;
   assign in_phase = (state == S_LOW) || (state == S_HIGH);
   assign last     = (cnt == LAST);
   // Offset wraps modulo 2^32; the two byte-lane bits are dropped so accesses are word aligned.
   assign word     = 17'((alu_result_in - MEM_BASE) >> 2);

   // SRAM chip/byte/output enables are permanently asserted.
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;
   assign sram_ce_n = 1'b0;
   assign sram_oe_n = 1'b0;

   // Next-state, phase counter and pipeline stall.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ready     = 1'b0;
      case (state)
         S_IDLE: begin
            ready = ~request;
            if (request) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end
         end
         S_LOW: begin
            if (last) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_HIGH: begin
            if (last) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_DONE: begin
            ready     = 1'b1;
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // SRAM pin drive: address/data only during LOW/HIGH; WE released on each phase's last cycle for hold time.
   always_comb begin
      sram_addr = '0;
      sram_we_n = 1'b1;
      dq_drive  = 1'b0;
      dq_out    = val_rm_in[15:0];
      if (in_phase) begin
         sram_addr = {word, (state == S_HIGH)};
         if (is_write) begin
            dq_drive  = 1'b1;
            sram_we_n = last;
            dq_out    = (state == S_HIGH) ? val_rm_in[31:16] : val_rm_in[15:0];
         end
      end
   end

   assign sram_dq = dq_drive ? dq_out : 16'hzzzz;

   // State register, low-half staging and load result update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         stage_lo      <= '0;
         read_data_out <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!is_write && (state == S_LOW) && last) begin
            stage_lo <= sram_dq;
         end
         // The high half lands in the same edge that enters DONE, so it is merged straight into the result.
         if (!is_write && (state == S_HIGH) && last) begin
            read_data_out <= {sram_dq, stage_lo};
         end
      end
   end

endmodule

// File: tb/tb_mem_sram_controller.sv
// tb/tb_mem_sram_controller.sv - self-checking bench for mem_sram_controller
module tb_mem_sram_controller;

   localparam int W    = 2;
   localparam int DONE = 2 * W + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en_in;
   logic        mem_w_en_in;
   logic [31:0] alu_result_in;
   logic [31:0] val_rm_in;
   logic        ready;
   logic [31:0] read_data_out;
   logic [17:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        sram_we_n;
   logic        sram_ub_n;
   logic        sram_lb_n;
   logic        sram_ce_n;
   logic        sram_oe_n;

   logic        probe;
   logic        tb_drive;
   logic [15:0] tb_dq;
   logic [15:0] sram_mem [0:262143];

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_rd;
   logic [31:0] ref_mem [int];
   time         prev_ready_t;

   mem_sram_controller #(.WAIT_CYCLES(W), .MEM_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .alu_result_in(alu_result_in), .val_rm_in(val_rm_in),
      .ready(ready), .read_data_out(read_data_out),
      .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n)
   );

   always #5 clk = ~clk;

   // External SRAM: drives the bus for loads (or a probe pattern), stores while WE is low.
   assign tb_drive = probe | (mem_r_en_in & ~mem_w_en_in);
   assign tb_dq    = probe ? 16'hA5A5 : sram_mem[sram_addr];
   assign sram_dq  = tb_drive ? tb_dq : 16'hzzzz;

   always @(posedge clk) begin
      if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] word_of(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - 32'd1024;
      return off[18:2];
   endfunction

   function automatic logic [31:0] ref_read(input logic [16:0] word);
      if (ref_mem.exists(int'(word))) return ref_mem[int'(word)];
      return 32'h0;
   endfunction

   // Check one cycle c (0 = request seen in IDLE, DONE = ready cycle) of an access.
   task automatic check_cycle(input int c, input logic w, input logic [16:0] word,
                              input logic [31:0] data, input logic [31:0] exp_rd);
      logic        low, high;
      logic [17:0] exp_addr;
      logic        exp_we;
      logic [31:0] exp_out;
      low      = (c >= 1) && (c <= W);
      high     = (c >= W + 1) && (c <= 2 * W);
      exp_addr = low ? {word, 1'b0} : (high ? {word, 1'b1} : 18'd0);
      exp_we   = !(w && (low || high) && (c != W) && (c != 2 * W));
      exp_out  = (c == DONE && !w) ? exp_rd : last_rd;
      chk($sformatf("c%0d ready", c), {31'd0, ready}, {31'd0, c == DONE});
      chk($sformatf("c%0d sram_addr", c), {14'd0, sram_addr}, {14'd0, exp_addr});
      chk($sformatf("c%0d sram_we_n", c), {31'd0, sram_we_n}, {31'd0, exp_we});
      chk($sformatf("c%0d read_data_out", c), read_data_out, exp_out);
      if (w && low)  chk($sformatf("c%0d dq low", c),  {16'd0, sram_dq}, {16'd0, data[15:0]});
      if (w && high) chk($sformatf("c%0d dq high", c), {16'd0, sram_dq}, {16'd0, data[31:16]});
      if (c == DONE && ready) begin
         if (prev_ready_t != 0) chk("ready spacing", 32'(($time - prev_ready_t) / 10), 32'(DONE + 1));
         prev_ready_t = $time;
      end
   endtask

   task automatic apply(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      probe         = 1'b0;
      mem_r_en_in   = r;
      mem_w_en_in   = w;
      alu_result_in = addr;
      val_rm_in     = data;
      #1;
   endtask

   task automatic run_from(input int first_c, input logic w, input logic [16:0] word,
                           input logic [31:0] data, input logic [31:0] exp_rd);
      for (int c = first_c; c <= DONE; c++) begin
         if (c > 0) begin
            @(negedge clk);
            #1;
         end
         check_cycle(c, w, word, data, exp_rd);
      end
      if (w) ref_mem[int'(word)] = data;
      else   last_rd = exp_rd;
   endtask

   task automatic access(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data,
                         input logic [16:0] word, input logic [31:0] exp_rd);
      apply(r, w, addr, data);
      run_from(0, w, word, data, exp_rd);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      mem_r_en_in = 1'b0;
      mem_w_en_in = 1'b0;
      probe       = 1'b1;
      #1;
      chk("idle ready", {31'd0, ready}, 32'd1);
      chk("idle sram_addr", {14'd0, sram_addr}, 32'd0);
      chk("idle sram_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("idle dq released", {16'd0, sram_dq}, 32'h0000A5A5);
      chk("idle read_data_out", read_data_out, last_rd);
      prev_ready_t = 0;
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] addr;
      logic [31:0] data;
      logic [16:0] exp_word;
      logic [31:0] exp_rd;
   } vec_t;

   initial begin
      vec_t vecs[8];
      logic r, w;
      logic [31:0] addr, data;
      logic [16:0] word;

      vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 17'd0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        17'd0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'h11112222, 17'd2, 32'h0};
      vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h33334444, 17'd1, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        17'd2, 32'h11112222};
      vecs[5] = '{1'b1, 1'b0, 32'd1031, 32'h0,        17'd1, 32'h33334444};
      vecs[6] = '{1'b1, 1'b1, 32'd1031, 32'h55556666, 17'd1, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 32'd1028, 32'h0,        17'd1, 32'h55556666};

      for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
      last_rd       = 32'h0;
      prev_ready_t  = 0;
      probe         = 1'b0;
      rst           = 1'b1;
      mem_r_en_in   = 1'b0;
      mem_w_en_in   = 1'b0;
      alu_result_in = 32'h0;
      val_rm_in     = 32'h0;

      // Reset held two cycles.
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset ready", {31'd0, ready}, 32'd1);
      chk("reset read_data_out", read_data_out, 32'h0);
      chk("reset sram_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("reset sram_addr", {14'd0, sram_addr}, 32'd0);
      rst = 1'b0;
      idle_cycle();

      // Reset during the HIGH phase of a load aborts it; the held request then restarts.
      apply(1'b1, 1'b0, 32'd1024, 32'h0);
      check_cycle(0, 1'b0, 17'd0, 32'h0, 32'h0);
      for (int c = 1; c <= W + 1; c++) begin
         @(negedge clk);
         #1;
         check_cycle(c, 1'b0, 17'd0, 32'h0, 32'h0);
      end
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("abort sram_addr", {14'd0, sram_addr}, 32'd0);
      chk("abort sram_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("abort ready", {31'd0, ready}, 32'd0);
      chk("abort read_data_out", read_data_out, 32'h0);
      rst = 1'b0;
      prev_ready_t = 0;
      run_from(1, 1'b0, 17'd0, 32'h0, 32'h0);
      idle_cycle();

      // Directed table, issued back to back.
      for (int i = 0; i < 8; i++) begin
         access(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].exp_word, vecs[i].exp_rd);
      end
      idle_cycle();

      // Randomized traffic against the word-level reference memory.
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            idle_cycle();
         end else begin
            r    = (kind <= 4) || (kind == 9);
            w    = (kind >= 5);
            addr = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            data = $urandom;
            word = word_of(addr);
            access(r, w, addr, data, word, w ? 32'h0 : ref_read(word));
         end
      end
      idle_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
